// File: rtl/jk_pkg.sv
// Shared encodings for the jk excitation driver.
// FSM states and {j,k} excitation codes.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Target-word valid/ready stream into the excitation driver.
// master = target source, slave = driver.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (
    output tgt_valid,
    output tgt_data,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    output tgt_ready
  );
endinterface

// File: rtl/jk_excite.sv
// Per-bit JK excitation: {j,k} that moves q to t in one edge.
// JK_TOGGLE_PREF_EN selects toggle for changing bits.
module jk_excite
  import jk_pkg::*;
(
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);

  logic [1:0] jk;

  always_comb begin
    jk = JK_HOLD;
    case ({q, t})
`ifdef JK_TOGGLE_PREF_EN
      2'b01:   jk = JK_TGL;
      2'b10:   jk = JK_TGL;
`else
      2'b01:   jk = JK_SET;
      2'b10:   jk = JK_RST;
`endif
      default: jk = JK_HOLD;
    endcase
  end

  assign {j, k} = jk;

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a jk flop bank toward each target word, then checks q.
// Build option JK_TOGGLE_PREF_EN: toggle-style excitation.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  jk_excitation_driver_if.slave  tgt,
  input  logic [WIDTH-1:0]       q_fb,
  output logic [WIDTH-1:0]       j,
  output logic [WIDTH-1:0]       k,
  output logic                   busy,
  output logic                   done,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       err_count
);

  state_t           state, state_n;
  logic [WIDTH-1:0] target, target_n;
  logic [WIDTH-1:0] j_n, k_n;
  logic [WIDTH-1:0] ex_j, ex_k;
  logic             done_n, mis_n;
  logic [CNT_W-1:0] err_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_excite u_ex (
      .q (q_fb[i]),
      .t (tgt.tgt_data[i]),
      .j (ex_j[i]),
      .k (ex_k[i])
    );
  end

  assign tgt.tgt_ready = (state == ST_IDLE) && !rst;
  assign busy          = (state != ST_IDLE);

  always_comb begin
    state_n  = state;
    target_n = target;
    j_n      = '0;
    k_n      = '0;
    done_n   = 1'b0;
    mis_n    = 1'b0;
    err_n    = err_count;
    unique case (state)
      ST_IDLE: begin
        if (tgt.tgt_valid) begin
          target_n = tgt.tgt_data;
          j_n      = ex_j;
          k_n      = ex_k;
          state_n  = ST_DRIVE;
        end
      end
      ST_DRIVE: state_n = ST_CHECK;
      ST_CHECK: begin
        done_n  = 1'b1;
        mis_n   = (q_fb != target);
        // saturate rather than wrap
        if (mis_n && (err_count != '1))
          err_n = err_count + CNT_W'(1);
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      target    <= '0;
      j         <= '0;
      k         <= '0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      j         <= j_n;
      k         <= k_n;
      done      <= done_n;
      mismatch  <= mis_n;
      err_count <= err_n;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver with a modelled 4-bit jk flop bank.
// Build with JK_TOGGLE_PREF_EN for the toggle-style variant.
module tb_jk_excitation_driver;

  localparam int W = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] fq = '0;
  logic [W-1:0] stuck = '0;
  logic [W-1:0] q_fb, j, k;
  logic         busy, done, mismatch;
  logic [C-1:0] err_count;

  int tests = 0;
  int fails = 0;
  int err_m = 0;

  jk_excitation_driver_if #(.WIDTH(W)) bus ();

  jk_excitation_driver #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt       (bus),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .err_count (err_count)
  );

  always #30 clk = ~clk;

  // jk flop bank: Q+ = J & ~Q | ~K & Q
  always @(posedge clk) fq <= (j & ~fq) | (~k & fq);
  assign q_fb = fq & ~stuck;

  function automatic logic [2*W-1:0] model_jk(input logic [W-1:0] q,
                                              input logic [W-1:0] t);
    logic [W-1:0] d;
    d = q ^ t;
`ifdef JK_TOGGLE_PREF_EN
    return {d, d};
`else
    return {d & t, d & q};
`endif
  endfunction

  task automatic wait_ready(output bit ok);
    for (int c = 0; c < 10 && !bus.tgt_ready; c++) @(negedge clk);
    ok = bus.tgt_ready;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL ready_timeout: tgt_ready=%b required 1", bus.tgt_ready);
    end
  endtask

  task automatic run_target(input logic [W-1:0] t);
    bit ok;
    logic [W-1:0] q0, exp_q;
    logic [2*W-1:0] exp_jk;
    logic exp_mis;
    wait_ready(ok);
    if (!ok) return;
    q0 = q_fb;
    exp_jk = model_jk(q0, t);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = t;
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = W'($urandom);
    tests++;
    if ({j, k} !== exp_jk || busy !== 1'b1 || bus.tgt_ready !== 1'b0) begin
      fails++;
      $display("FAIL drive: jk=%b busy=%b rdy=%b required jk=%b busy=1 rdy=0",
               {j, k}, busy, bus.tgt_ready, exp_jk);
    end
`ifndef JK_TOGGLE_PREF_EN
    tests++;
    if ((j & k) !== '0) begin
      fails++;
      $display("FAIL no_toggle: j&k=%b required 0000", j & k);
    end
`endif
    @(negedge clk);
    tests++;
    if ({j, k} !== '0 || done !== 1'b0) begin
      fails++;
      $display("FAIL check_hold: jk=%b done=%b required jk=0 done=0",
               {j, k}, done);
    end
    @(negedge clk);
    exp_q   = t & ~stuck;
    exp_mis = (exp_q != t);
    if (exp_mis && err_m < 255) err_m++;
    tests++;
    if (done !== 1'b1 || mismatch !== exp_mis || err_count !== C'(err_m) ||
        q_fb !== exp_q || busy !== 1'b0) begin
      fails++;
      $display("FAIL result: done=%b mis=%b err=%0d q=%b busy=%b required 1 %b %0d %b 0",
               done, mismatch, err_count, q_fb, busy, exp_mis, err_m, exp_q);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (j !== '0 || k !== '0 || bus.tgt_ready !== 1'b0 || done !== 1'b0 ||
        err_count !== '0 || mismatch !== 1'b0) begin
      fails++;
      $display("FAIL reset: j=%b k=%b rdy=%b done=%b err=%0d required 0",
               j, k, bus.tgt_ready, done, err_count);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.tgt_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: rdy=%b busy=%b required 1 0",
               bus.tgt_ready, busy);
    end
  endtask

  task automatic test_set_reset();
    run_target(4'b1010);
    run_target(4'b0110);
  endtask

  task automatic test_hold();
    run_target(4'b0110);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc = 0;
    int first = -1;
    int last = -1;
    wait_ready(ok);
    if (!ok) return;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = q_fb;
    for (int c = 0; c < 6; c++) begin
      if (bus.tgt_ready) begin
        acc++;
        if (first < 0) first = c;
        last = c;
      end
      @(negedge clk);
    end
    bus.tgt_valid = 1'b0;
    tests++;
    if (acc != 2 || (last - first) != 3) begin
      fails++;
      $display("FAIL back_to_back: accepts=%0d gap=%0d required 2 3",
               acc, last - first);
    end
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_target(W'($urandom));
    end
  endtask

  task automatic test_mismatch();
    run_target(4'b0000);
    stuck = 4'b0001;
    for (int n = 0; n < 300; n++) run_target(4'b0001);
    tests++;
    if (err_count !== 8'd255) begin
      fails++;
      $display("FAIL saturate: err=%0d required 255", err_count);
    end
    stuck = '0;
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = ~q_fb;
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    err_m = 0;
    tests++;
    if (j !== '0 || k !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        bus.tgt_ready !== 1'b0 || err_count !== '0) begin
      fails++;
      $display("FAIL reset_mid: j=%b k=%b busy=%b done=%b rdy=%b err=%0d required 0",
               j, k, busy, done, bus.tgt_ready, err_count);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_done: done=%b busy=%b required 0 0", done, busy);
      end
    end
    run_target(4'b1001);
  endtask

`ifdef JK_TOGGLE_PREF_EN
  task automatic test_toggle();
    bit ok;
    run_target(4'b0011);
    wait_ready(ok);
    if (!ok) return;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b0101;
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    tests++;
    if (j !== 4'b0110 || k !== 4'b0110) begin
      fails++;
      $display("FAIL toggle_jk: j=%b k=%b required 0110 0110", j, k);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (done !== 1'b1 || mismatch !== 1'b0 || q_fb !== 4'b0101) begin
      fails++;
      $display("FAIL toggle_result: done=%b mis=%b q=%b required 1 0 0101",
               done, mismatch, q_fb);
    end
  endtask
`endif

  initial begin
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    test_reset();
    test_set_reset();
    test_hold();
    test_back_to_back();
    test_random();
    test_mismatch();
    test_reset_mid_op();
`ifdef JK_TOGGLE_PREF_EN
    test_toggle();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
